// File: rtl/serial_comparator_framed.sv
// Digit-serial magnitude comparator with frame counting, running verdict and
// a registered final verdict that is announced by a one-cycle res_valid pulse.
module serial_comparator_framed #(
    parameter int DIGIT_W   = 1,
    parameter int N_DIGITS  = 16,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               run_lt,
    output logic               run_eq,
    output logic               run_gt,
    output logic               busy,
    output logic               res_valid,
    output logic               res_lt,
    output logic               res_eq,
    output logic               res_gt
);

    localparam int                 CW      = $clog2(N_DIGITS);
    localparam logic [CW-1:0]      LAST    = CW'(N_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] TOP_BIT = DIGIT_W'(1) << (DIGIT_W - 1);

    logic [CW-1:0]      r_cnt;
    logic               r_prev_lt, r_prev_eq, r_prev_gt;

    logic               w_frame_start, w_last, w_sign_digit;
    logic [DIGIT_W-1:0] w_flip, w_a, w_b;
    logic               w_d_lt, w_d_eq, w_d_gt;
    logic               w_base_lt, w_base_eq, w_base_gt;
    logic               w_lt, w_eq, w_gt;

    // A clear restarts the frame, so the digit presented with it is digit 0.
    assign w_frame_start = clear || (r_cnt == '0);
    assign w_last        = !clear && (r_cnt == LAST);
    assign w_sign_digit  = (MSB_FIRST != 0) ? w_frame_start : w_last;

    // Inverting the sign bit maps two's complement onto unsigned ordering.
    assign w_flip = ((SIGNED != 0) && w_sign_digit) ? TOP_BIT : '0;
    assign w_a    = a_digit ^ w_flip;
    assign w_b    = b_digit ^ w_flip;

    assign w_d_lt = (w_a < w_b);
    assign w_d_eq = (w_a == w_b);
    assign w_d_gt = (w_a > w_b);

    always_comb begin
        w_base_lt = 1'b0;
        w_base_eq = 1'b1;
        w_base_gt = 1'b0;
        if (!w_frame_start) begin
            w_base_lt = r_prev_lt;
            w_base_eq = r_prev_eq;
            w_base_gt = r_prev_gt;
        end
    end

    // MSB-first: the first difference wins; LSB-first: the latest one wins.
    always_comb begin
        w_eq = w_base_eq & w_d_eq;
        w_lt = 1'b0;
        w_gt = 1'b0;
        if (MSB_FIRST != 0) begin
            w_lt = w_base_lt | (w_base_eq & w_d_lt);
            w_gt = w_base_gt | (w_base_eq & w_d_gt);
        end else begin
            w_lt = w_d_lt | (w_d_eq & w_base_lt);
            w_gt = w_d_gt | (w_d_eq & w_base_gt);
        end
    end

    assign run_lt = valid ? w_lt : r_prev_lt;
    assign run_eq = valid ? w_eq : r_prev_eq;
    assign run_gt = valid ? w_gt : r_prev_gt;
    assign busy   = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_prev_lt <= 1'b0;
            r_prev_eq <= 1'b1;
            r_prev_gt <= 1'b0;
            res_valid <= 1'b0;
            res_lt    <= 1'b0;
            res_eq    <= 1'b1;
            res_gt    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (valid) begin
                if (w_last) begin
                    res_lt    <= w_lt;
                    res_eq    <= w_eq;
                    res_gt    <= w_gt;
                    res_valid <= 1'b1;
                    r_cnt     <= '0;
                    r_prev_lt <= 1'b0;
                    r_prev_eq <= 1'b1;
                    r_prev_gt <= 1'b0;
                end else begin
                    r_prev_lt <= w_lt;
                    r_prev_eq <= w_eq;
                    r_prev_gt <= w_gt;
                    r_cnt     <= clear ? CW'(1) : r_cnt + CW'(1);
                end
            end else if (clear) begin
                r_cnt     <= '0;
                r_prev_lt <= 1'b0;
                r_prev_eq <= 1'b1;
                r_prev_gt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Directed bench for serial_comparator_framed: four instances cover MSB/LSB-first
// ordering and unsigned/signed operands with hand-computed verdicts.
module tb_serial_comparator_framed;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v4, c4, v1, c1;
    logic [3:0] a4, b4;
    logic       a1, b1;

    wire [3:0][2:0] run_a;
    wire [3:0][2:0] res_a;
    wire [3:0]      rv_a;
    wire [3:0]      busy_a;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // u0: 4-bit digits MSB-first unsigned, u1: same but signed
    serial_comparator_framed #(.DIGIT_W(4), .N_DIGITS(4), .MSB_FIRST(1), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .clear(c4), .valid(v4), .a_digit(a4), .b_digit(b4),
        .run_lt(run_a[0][2]), .run_eq(run_a[0][1]), .run_gt(run_a[0][0]), .busy(busy_a[0]),
        .res_valid(rv_a[0]), .res_lt(res_a[0][2]), .res_eq(res_a[0][1]), .res_gt(res_a[0][0]));

    serial_comparator_framed #(.DIGIT_W(4), .N_DIGITS(4), .MSB_FIRST(1), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .clear(c4), .valid(v4), .a_digit(a4), .b_digit(b4),
        .run_lt(run_a[1][2]), .run_eq(run_a[1][1]), .run_gt(run_a[1][0]), .busy(busy_a[1]),
        .res_valid(rv_a[1]), .res_lt(res_a[1][2]), .res_eq(res_a[1][1]), .res_gt(res_a[1][0]));

    // u2: 1-bit LSB-first unsigned, u3: same but signed
    serial_comparator_framed #(.DIGIT_W(1), .N_DIGITS(16), .MSB_FIRST(0), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .clear(c1), .valid(v1), .a_digit(a1), .b_digit(b1),
        .run_lt(run_a[2][2]), .run_eq(run_a[2][1]), .run_gt(run_a[2][0]), .busy(busy_a[2]),
        .res_valid(rv_a[2]), .res_lt(res_a[2][2]), .res_eq(res_a[2][1]), .res_gt(res_a[2][0]));

    serial_comparator_framed #(.DIGIT_W(1), .N_DIGITS(16), .MSB_FIRST(0), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .clear(c1), .valid(v1), .a_digit(a1), .b_digit(b1),
        .run_lt(run_a[3][2]), .run_eq(run_a[3][1]), .run_gt(run_a[3][0]), .busy(busy_a[3]),
        .res_valid(rv_a[3]), .res_lt(res_a[3][2]), .res_eq(res_a[3][1]), .res_gt(res_a[3][0]));

    // driver tasks: change inputs just after the falling edge, return 1 ns later
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v, input logic c);
        @(negedge clk);
        v4 = v; c4 = c; a4 = a; b4 = b;
        #1;
    endtask

    task automatic drive1(input logic a, input logic b, input logic v);
        @(negedge clk);
        v1 = v; a1 = a; b1 = b;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (run_a[i] !== EQ) begin n_errs++; $display("FAIL reset_run u%0d got=%b exp=%b", i, run_a[i], EQ); end
            n_checks++; if (res_a[i] !== EQ) begin n_errs++; $display("FAIL reset_res u%0d got=%b exp=%b", i, res_a[i], EQ); end
            n_checks++; if (rv_a[i] !== 1'b0) begin n_errs++; $display("FAIL reset_res_valid u%0d got=%b exp=0", i, rv_a[i]); end
            n_checks++; if (busy_a[i] !== 1'b0) begin n_errs++; $display("FAIL reset_busy u%0d got=%b exp=0", i, busy_a[i]); end
        end
    endtask

    task automatic test_msb_unsigned;
        logic [15:0] a, b;
        logic [2:0]  exp_run [4];
        a = 16'h1234; b = 16'h1243;
        exp_run = '{EQ, EQ, LT, LT};
        for (int i = 0; i < 4; i++) begin
            drive4(a[15-4*i -: 4], b[15-4*i -: 4], 1'b1, 1'b0);
            n_checks++; if (run_a[0] !== exp_run[i]) begin n_errs++; $display("FAIL msb_run d%0d got=%b exp=%b", i, run_a[0], exp_run[i]); end
            n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL msb_no_pulse d%0d got=%b exp=0", i, rv_a[0]); end
            n_checks++; if (busy_a[0] !== (i != 0)) begin n_errs++; $display("FAIL msb_busy d%0d got=%b exp=%b", i, busy_a[0], (i != 0)); end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL msb_pulse got=%b exp=1", rv_a[0]); end
        n_checks++; if (res_a[0] !== LT) begin n_errs++; $display("FAIL msb_res got=%b exp=%b", res_a[0], LT); end
        n_checks++; if (busy_a[0] !== 1'b0) begin n_errs++; $display("FAIL msb_busy_end got=%b exp=0", busy_a[0]); end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL msb_pulse_once got=%b exp=0", rv_a[0]); end
        n_checks++; if (res_a[0] !== LT) begin n_errs++; $display("FAIL msb_res_hold got=%b exp=%b", res_a[0], LT); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a [2];
        logic [15:0] b [2];
        logic [2:0]  exp_run [2];
        int          t1, t2;
        a = '{16'hBEEF, 16'h8000};
        b = '{16'hBEEF, 16'h7FFF};
        exp_run = '{EQ, GT};
        t1 = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                drive4(a[f][15-4*i -: 4], b[f][15-4*i -: 4], 1'b1, 1'b0);
                n_checks++; if (run_a[0] !== exp_run[f]) begin n_errs++; $display("FAIL b2b_run f%0d d%0d got=%b exp=%b", f, i, run_a[0], exp_run[f]); end
                if (f == 1 && i == 0) begin
                    t1 = cyc;
                    n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL b2b_pulse1 got=%b exp=1", rv_a[0]); end
                    n_checks++; if (res_a[0] !== EQ) begin n_errs++; $display("FAIL b2b_res1 got=%b exp=%b", res_a[0], EQ); end
                end else begin
                    n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL b2b_no_pulse f%0d d%0d got=%b exp=0", f, i, rv_a[0]); end
                end
            end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        t2 = cyc;
        n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL b2b_pulse2 got=%b exp=1", rv_a[0]); end
        n_checks++; if (res_a[0] !== GT) begin n_errs++; $display("FAIL b2b_res2 got=%b exp=%b", res_a[0], GT); end
        n_checks++; if (t2 - t1 !== 4) begin n_errs++; $display("FAIL b2b_spacing got=%0d exp=4", t2 - t1); end
    endtask

    task automatic test_signed_msb;
        logic [15:0] a [2];
        logic [15:0] b [2];
        logic [2:0]  exp_run0 [2][4];
        logic [2:0]  exp_run1 [2][4];
        logic [2:0]  exp_res0 [2];
        logic [2:0]  exp_res1 [2];
        a = '{16'hFFFF, 16'h0800};
        b = '{16'h0001, 16'h0100};
        exp_run0 = '{'{GT, GT, GT, GT}, '{EQ, GT, GT, GT}};
        exp_run1 = '{'{LT, LT, LT, LT}, '{EQ, GT, GT, GT}};
        exp_res0 = '{GT, GT};
        exp_res1 = '{LT, GT};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                drive4(a[f][15-4*i -: 4], b[f][15-4*i -: 4], 1'b1, 1'b0);
                n_checks++; if (run_a[0] !== exp_run0[f][i]) begin n_errs++; $display("FAIL sgn_run_unsigned f%0d d%0d got=%b exp=%b", f, i, run_a[0], exp_run0[f][i]); end
                n_checks++; if (run_a[1] !== exp_run1[f][i]) begin n_errs++; $display("FAIL sgn_run_signed f%0d d%0d got=%b exp=%b", f, i, run_a[1], exp_run1[f][i]); end
            end
            drive4(4'h0, 4'h0, 1'b0, 1'b0);
            n_checks++; if (rv_a[1] !== 1'b1) begin n_errs++; $display("FAIL sgn_pulse f%0d got=%b exp=1", f, rv_a[1]); end
            n_checks++; if (res_a[0] !== exp_res0[f]) begin n_errs++; $display("FAIL sgn_res_unsigned f%0d got=%b exp=%b", f, res_a[0], exp_res0[f]); end
            n_checks++; if (res_a[1] !== exp_res1[f]) begin n_errs++; $display("FAIL sgn_res_signed f%0d got=%b exp=%b", f, res_a[1], exp_res1[f]); end
        end
    endtask

    task automatic test_lsb_first;
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic [2:0]  exp_b1 [3];
        logic [2:0]  exp_b2 [3];
        logic [2:0]  exp_last2 [3];
        logic [2:0]  exp_last3 [3];
        logic [2:0]  exp_res2 [3];
        logic [2:0]  exp_res3 [3];
        a = '{16'h0005, 16'h8000, 16'h0001};
        b = '{16'h0003, 16'h0001, 16'h0000};
        exp_b1    = '{LT, LT, GT};
        exp_b2    = '{GT, LT, GT};
        exp_last2 = '{GT, GT, GT};
        exp_last3 = '{GT, LT, GT};
        exp_res2  = '{GT, GT, GT};
        exp_res3  = '{GT, LT, GT};
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                drive1(a[f][i], b[f][i], 1'b1);
                if (i == 1 || i == 2) begin
                    n_checks++; if (run_a[2] !== ((i == 1) ? exp_b1[f] : exp_b2[f])) begin n_errs++; $display("FAIL lsb_run_mid f%0d b%0d got=%b", f, i, run_a[2]); end
                    n_checks++; if (run_a[3] !== ((i == 1) ? exp_b1[f] : exp_b2[f])) begin n_errs++; $display("FAIL lsb_run_mid_signed f%0d b%0d got=%b", f, i, run_a[3]); end
                end
                if (i == 15) begin
                    n_checks++; if (run_a[2] !== exp_last2[f]) begin n_errs++; $display("FAIL lsb_run_last f%0d got=%b exp=%b", f, run_a[2], exp_last2[f]); end
                    n_checks++; if (run_a[3] !== exp_last3[f]) begin n_errs++; $display("FAIL lsb_run_last_signed f%0d got=%b exp=%b", f, run_a[3], exp_last3[f]); end
                    n_checks++; if (busy_a[2] !== 1'b1) begin n_errs++; $display("FAIL lsb_busy f%0d got=%b exp=1", f, busy_a[2]); end
                end
            end
            drive1(1'b0, 1'b0, 1'b0);
            n_checks++; if (rv_a[2] !== 1'b1) begin n_errs++; $display("FAIL lsb_pulse f%0d got=%b exp=1", f, rv_a[2]); end
            n_checks++; if (res_a[2] !== exp_res2[f]) begin n_errs++; $display("FAIL lsb_res_unsigned f%0d got=%b exp=%b", f, res_a[2], exp_res2[f]); end
            n_checks++; if (res_a[3] !== exp_res3[f]) begin n_errs++; $display("FAIL lsb_res_signed f%0d got=%b exp=%b", f, res_a[3], exp_res3[f]); end
        end
    endtask

    task automatic test_abort;
        logic [3:0] a [6];
        logic [3:0] b [6];
        logic       c [6];
        logic [2:0] exp_run [6];
        a = '{4'hF, 4'h0, 4'h1, 4'h5, 4'h5, 4'h5};
        b = '{4'h0, 4'h0, 4'h2, 4'h5, 4'h5, 4'h5};
        c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_run = '{GT, GT, LT, LT, LT, LT};
        for (int i = 0; i < 6; i++) begin
            drive4(a[i], b[i], 1'b1, c[i]);
            n_checks++; if (run_a[0] !== exp_run[i]) begin n_errs++; $display("FAIL abort_run d%0d got=%b exp=%b", i, run_a[0], exp_run[i]); end
            n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL abort_no_pulse d%0d got=%b exp=0", i, rv_a[0]); end
            n_checks++; if (res_a[0] !== GT) begin n_errs++; $display("FAIL abort_res_held d%0d got=%b exp=%b", i, res_a[0], GT); end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL abort_pulse got=%b exp=1", rv_a[0]); end
        n_checks++; if (res_a[0] !== LT) begin n_errs++; $display("FAIL abort_res got=%b exp=%b", res_a[0], LT); end
    endtask

    task automatic test_gaps;
        logic [15:0] a, b;
        logic [2:0]  exp_run [4];
        a = 16'h1234; b = 16'h1243;
        exp_run = '{EQ, EQ, LT, LT};
        for (int i = 0; i < 4; i++) begin
            drive4(a[15-4*i -: 4], b[15-4*i -: 4], 1'b1, 1'b0);
            n_checks++; if (run_a[0] !== exp_run[i]) begin n_errs++; $display("FAIL gap_run d%0d got=%b exp=%b", i, run_a[0], exp_run[i]); end
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    drive4(4'h0, 4'h0, 1'b0, 1'b0);
                    n_checks++; if (busy_a[0] !== 1'b1) begin n_errs++; $display("FAIL gap_busy d%0d g%0d got=%b exp=1", i, g, busy_a[0]); end
                    n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL gap_no_pulse d%0d g%0d got=%b exp=0", i, g, rv_a[0]); end
                    n_checks++; if (run_a[0] !== exp_run[i]) begin n_errs++; $display("FAIL gap_run_hold d%0d g%0d got=%b exp=%b", i, g, run_a[0], exp_run[i]); end
                end
            end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL gap_pulse got=%b exp=1", rv_a[0]); end
        n_checks++; if (res_a[0] !== LT) begin n_errs++; $display("FAIL gap_res got=%b exp=%b", res_a[0], LT); end
        n_checks++; if (busy_a[0] !== 1'b0) begin n_errs++; $display("FAIL gap_busy_end got=%b exp=0", busy_a[0]); end
    endtask

    task automatic test_reset_mid_frame;
        drive4(4'h3, 4'h1, 1'b1, 1'b0);
        drive4(4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; v4 = 1'b1; a4 = 4'h7; b4 = 4'h7;
        @(negedge clk);
        rst = 1'b0; v4 = 1'b0;
        #1;
        n_checks++; if (run_a[0] !== EQ) begin n_errs++; $display("FAIL rst_mid_run got=%b exp=%b", run_a[0], EQ); end
        n_checks++; if (busy_a[0] !== 1'b0) begin n_errs++; $display("FAIL rst_mid_busy got=%b exp=0", busy_a[0]); end
        n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL rst_mid_pulse got=%b exp=0", rv_a[0]); end
        n_checks++; if (res_a[0] !== EQ) begin n_errs++; $display("FAIL rst_mid_res got=%b exp=%b", res_a[0], EQ); end
        for (int i = 0; i < 4; i++) begin
            drive4(4'h2, 4'h1, 1'b1, 1'b0);
            n_checks++; if (rv_a[0] !== 1'b0) begin n_errs++; $display("FAIL rst_fresh_no_pulse d%0d got=%b exp=0", i, rv_a[0]); end
            n_checks++; if (busy_a[0] !== (i != 0)) begin n_errs++; $display("FAIL rst_fresh_busy d%0d got=%b exp=%b", i, busy_a[0], (i != 0)); end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rv_a[0] !== 1'b1) begin n_errs++; $display("FAIL rst_fresh_pulse got=%b exp=1", rv_a[0]); end
        n_checks++; if (res_a[0] !== GT) begin n_errs++; $display("FAIL rst_fresh_res got=%b exp=%b", res_a[0], GT); end
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; c4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        v1 = 1'b0; c1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        test_reset;
        test_msb_unsigned;
        test_back_to_back;
        test_signed_msb;
        test_lsb_first;
        test_abort;
        test_gaps;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
